// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master command port among NUM_REQUESTERS clients.
// Optional watchdog on stalled transfers is built when SPI_ARB_TIMEOUT_EN is defined.
module spi_master_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDRESS_WIDTH  = 15,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                    clock_i,
  input  logic                                    reset_i,
  input  logic [NUM_REQUESTERS-1:0]               request_valid_i,
  output logic [NUM_REQUESTERS-1:0]               request_ready_o,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]    request_data_i,
  input  logic [NUM_REQUESTERS*ADDRESS_WIDTH-1:0] request_address_i,
  input  logic [NUM_REQUESTERS-1:0]               request_read_write_i,
  output logic [NUM_REQUESTERS-1:0]               response_valid_o,
  output logic [DATA_WIDTH-1:0]                   response_data_o,
  output logic                                    response_error_o,
  output logic [DATA_WIDTH-1:0]                   spi_data_o,
  output logic [ADDRESS_WIDTH-1:0]                spi_address_o,
  output logic                                    spi_read_write_o,
  output logic                                    spi_enable_o,
  input  logic                                    spi_busy_i,
  input  logic [DATA_WIDTH-1:0]                   spi_read_data_i
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          last_grant_q;
  logic [IDX_W-1:0]          grant_q;
  logic [NUM_REQUESTERS-1:0] request_ready_q;
  logic [NUM_REQUESTERS-1:0] response_valid_q;
  logic [DATA_WIDTH-1:0]     response_data_q;
  logic [DATA_WIDTH-1:0]     spi_data_q;
  logic [ADDRESS_WIDTH-1:0]  spi_address_q;
  logic                      spi_read_write_q;
  logic                      spi_enable_q;

  logic [IDX_W-1:0]          pick_idx_d;
  logic                      pick_found_d;
  logic                      tmo_hit;

  // Search starts just above the last served client so it drops to lowest priority.
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick_idx_d   = '0;
    pick_found_d = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQUESTERS);
      if (!pick_found_d && request_valid_i[cand]) begin
        pick_found_d = 1'b1;
        pick_idx_d   = cand;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             response_error_q;
  assign tmo_hit          = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
  assign response_error_o = response_error_q;
`else
  assign tmo_hit          = 1'b0;
  assign response_error_o = 1'b0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      last_grant_q     <= IDX_W'(NUM_REQUESTERS - 1);
      grant_q          <= '0;
      request_ready_q  <= '0;
      response_valid_q <= '0;
      response_data_q  <= '0;
      spi_data_q       <= '0;
      spi_address_q    <= '0;
      spi_read_write_q <= 1'b0;
      spi_enable_q     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      tmo_cnt_q        <= '0;
      response_error_q <= 1'b0;
`endif
    end else begin
      request_ready_q  <= '0;
      response_valid_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (pick_found_d && !spi_busy_i) begin
            grant_q          <= pick_idx_d;
            spi_data_q       <= request_data_i[pick_idx_d*DATA_WIDTH +: DATA_WIDTH];
            spi_address_q    <= request_address_i[pick_idx_d*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            spi_read_write_q <= request_read_write_i[pick_idx_d];
            request_ready_q  <= NUM_REQUESTERS'(1) << pick_idx_d;
            state_q          <= S_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_cnt_q        <= '0;
`endif
          end
        end
        S_ISSUE: begin
          spi_enable_q <= 1'b1;
          state_q      <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          if (tmo_hit) begin
            spi_enable_q     <= 1'b0;
            response_data_q  <= '0;
            response_valid_q <= NUM_REQUESTERS'(1) << grant_q;
            state_q          <= S_RESPOND;
`ifdef SPI_ARB_TIMEOUT_EN
            response_error_q <= 1'b1;
`endif
          end else if (state_q == S_WAIT_BUSY) begin
            if (spi_busy_i) begin
              spi_enable_q <= 1'b0;
              state_q      <= S_WAIT_DONE;
            end
          end else if (!spi_busy_i) begin
            response_data_q  <= spi_read_write_q ? spi_read_data_i : '0;
            response_valid_q <= NUM_REQUESTERS'(1) << grant_q;
            state_q          <= S_RESPOND;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          if (!tmo_hit) tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
        end
        S_RESPOND: begin
          last_grant_q <= grant_q;
          state_q      <= S_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
          response_error_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign request_ready_o  = request_ready_q;
  assign response_valid_o = response_valid_q;
  assign response_data_o  = response_data_q;
  assign spi_data_o       = spi_data_q;
  assign spi_address_o    = spi_address_q;
  assign spi_read_write_o = spi_read_write_q;
  assign spi_enable_o     = spi_enable_q;

endmodule
